// File: rtl/vga_ui_pkg.sv
// Shared types and defaults for the VGA quadrant-selection UI blocks.
package vga_ui_pkg;

    // UI mode sequence: browse the grid, hand a quadrant to the
    // interpolator, wait for it, then show the result until "back".
    typedef enum logic [1:0] {
        BROWSE  = 2'd0,
        REQUEST = 2'd1,
        PROCESS = 2'd2,
        SHOW    = 2'd3
    } ui_state_t;

    localparam int GRID_DIM          = 4;
    localparam int COORD_W           = 10;
    localparam int IMG_X0_DEFAULT    = 120;
    localparam int IMG_Y0_DEFAULT    = 40;
    localparam int QUAD_SIZE_DEFAULT = 100;

    // Screen origin of the quadrant at grid index idx along one axis.
    function automatic logic [COORD_W-1:0] quad_origin(input int base,
                                                       input logic [1:0] idx,
                                                       input int size);
        return COORD_W'(base + int'(idx) * size);
    endfunction

endpackage

// File: rtl/quad_cursor_ctrl_if.sv
// Quadrant request handshake between the cursor controller (master)
// and the interpolation engine (slave).
interface quad_cursor_ctrl_if;
    import vga_ui_pkg::*;

    logic               sel_valid;
    logic               sel_ready;
    logic [COORD_W-1:0] quad_x0;
    logic [COORD_W-1:0] quad_y0;
    logic               interp_done;

    modport master (
        output sel_valid, quad_x0, quad_y0,
        input  sel_ready, interp_done
    );

    modport slave (
        input  sel_valid, quad_x0, quad_y0,
        output sel_ready, interp_done
    );
endinterface

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stability counter,
// and a one-cycle pulse when a debounced press (0 -> 1) is accepted.
// Releases are debounced the same way but produce no pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_p
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Synchronise, count consecutive cycles at the new level, accept on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic, so every flop sees pre-edge values.
            sync_q  <= {sync_q[0], btn};
            press_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_p = press_q;
endmodule

// File: rtl/quad_cursor_ctrl.sv
// Quadrant cursor controller: debounced buttons move a 4x4 cursor, select
// hands the quadrant origin to the interpolator, and display-facing outputs
// (pos_cursor, start) are shadowed so they only change on frame_start.
// Build option: define QUAD_CURSOR_WRAP_EN to wrap cursor moves modulo 4
// per axis; otherwise moves saturate at 0 and 3.
module quad_cursor_ctrl
    import vga_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int IMG_X0          = IMG_X0_DEFAULT,
    parameter int IMG_Y0          = IMG_Y0_DEFAULT,
    parameter int QUAD_SIZE       = QUAD_SIZE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_sel,
    input  logic                      btn_back,
    input  logic                      frame_start,
    quad_cursor_ctrl_if.master        sel_bus,
    output logic [3:0]                pos_cursor,
    output logic                      start
);
    localparam logic [1:0] MAX_IDX = 2'(GRID_DIM - 1);
    localparam int B_LEFT = 0, B_RIGHT = 1, B_UP = 2, B_DOWN = 3, B_SEL = 4, B_BACK = 5;

    logic [5:0] btn_raw;
    logic [5:0] btn_p;

    assign btn_raw = {btn_back, btn_sel, btn_down, btn_up, btn_right, btn_left};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn_raw[i]),
            .press_p (btn_p[i])
        );
    end

    // One axis step; opposing pulses in the same cycle cancel.
    function automatic logic [1:0] step_idx(input logic [1:0] cur,
                                            input logic inc, input logic dec);
        logic [1:0] nxt;
        nxt = cur;
`ifdef QUAD_CURSOR_WRAP_EN
        if (inc && !dec)      nxt = cur + 2'd1;
        else if (dec && !inc) nxt = cur - 2'd1;
`else
        if (inc && !dec && cur != MAX_IDX) nxt = cur + 2'd1;
        else if (dec && !inc && cur != 2'd0) nxt = cur - 2'd1;
`endif
        return nxt;
    endfunction

    ui_state_t  state_q, state_d;
    logic [1:0] row_q, col_q;
    logic [COORD_W-1:0] quad_x0_q, quad_y0_q;
    logic [3:0] pos_q;
    logic       start_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BROWSE;
        else        state_q <= state_d;
    end

    // Next-state logic; each state listens only to its own trigger.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            BROWSE:  if (btn_p[B_SEL])        state_d = REQUEST;
            REQUEST: if (sel_bus.sel_ready)   state_d = PROCESS;
            PROCESS: if (sel_bus.interp_done) state_d = SHOW;
            SHOW:    if (btn_p[B_BACK])       state_d = BROWSE;
            default:                          state_d = BROWSE;
        endcase
    end

    // Cursor moves and origin latch, both only while browsing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            col_q     <= '0;
            quad_x0_q <= COORD_W'(IMG_X0);
            quad_y0_q <= COORD_W'(IMG_Y0);
        end else if (state_q == BROWSE) begin
            col_q <= step_idx(col_q, btn_p[B_RIGHT], btn_p[B_LEFT]);
            row_q <= step_idx(row_q, btn_p[B_DOWN], btn_p[B_UP]);
            if (btn_p[B_SEL]) begin
                quad_x0_q <= quad_origin(IMG_X0, col_q, QUAD_SIZE);
                quad_y0_q <= quad_origin(IMG_Y0, row_q, QUAD_SIZE);
            end
        end
    end

    // Frame-synchronous shadow of the display-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            start_q <= 1'b0;
        end else if (frame_start) begin
            pos_q   <= {row_q, col_q};
            start_q <= (state_q == SHOW);
        end
    end

    assign sel_bus.sel_valid = (state_q == REQUEST);
    assign sel_bus.quad_x0   = quad_x0_q;
    assign sel_bus.quad_y0   = quad_y0_q;
    assign pos_cursor        = pos_q;
    assign start             = start_q;
endmodule

// File: tb/tb_quad_cursor_ctrl.sv
// Directed bench for quad_cursor_ctrl with DEBOUNCE_CYCLES=4 and a
// free-running frame_start every 50 cycles. Expectations follow the
// QUAD_CURSOR_WRAP_EN setting of the build.
module tb_quad_cursor_ctrl;
    localparam int L = 0, R = 1, U = 2, D = 3, S = 4, B = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btns = '0;
    logic       frame_start = 1'b0;
    logic [3:0] pos_cursor;
    logic       start;

    int errors = 0;
    int checks = 0;

    quad_cursor_ctrl_if sel_bus ();

    quad_cursor_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_left    (btns[L]),
        .btn_right   (btns[R]),
        .btn_up      (btns[U]),
        .btn_down    (btns[D]),
        .btn_sel     (btns[S]),
        .btn_back    (btns[B]),
        .frame_start (frame_start),
        .sel_bus     (sel_bus),
        .pos_cursor  (pos_cursor),
        .start       (start)
    );

    always #5 clk = ~clk;

    // frame_start: one cycle high every 50 cycles, changed on falling edges.
    initial begin
        forever begin
            repeat (49) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full press: hold long enough to be accepted, then release long enough to settle.
    task automatic press(input int idx);
        btns[idx] = 1'b1;
        repeat (10) @(negedge clk);
        btns[idx] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Wait for the next frame_start edge, then land on the following falling edge.
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            if (frame_start) seen = 1'b1;
        end
        check("frame_timeout", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    // Press select and wait (bounded) for the request to appear.
    task automatic select_quad();
        bit seen;
        seen = 1'b0;
        btns[S] = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (sel_bus.sel_valid) seen = 1'b1;
        end
        check("sel_valid_rise", 32'(seen), 32'd1);
        btns[S] = 1'b0;
    endtask

    initial begin
        int exp_pos;
        sel_bus.sel_ready   = 1'b0;
        sel_bus.interp_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state as seen after the first frame.
        wait_frame();
        check("rst_pos", 32'(pos_cursor), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_valid", 32'(sel_bus.sel_valid), 32'd0);
        check("rst_x0", 32'(sel_bus.quad_x0), 32'd120);
        check("rst_y0", 32'(sel_bus.quad_y0), 32'd40);

        // Right + down -> row 1, col 1.
        press(R);
        press(D);
        wait_frame();
        check("move_rd", 32'(pos_cursor), 32'd5);

        // 3-cycle glitch on left is rejected.
        btns[L] = 1'b1;
        repeat (3) @(negedge clk);
        btns[L] = 1'b0;
        repeat (10) @(negedge clk);
        wait_frame();
        check("glitch", 32'(pos_cursor), 32'd5);

        // Back to col 0, then four rights.
        press(L);
        wait_frame();
        check("left_to_0", 32'(pos_cursor), 32'd4);
        for (int i = 0; i < 4; i++) press(R);
        wait_frame();
`ifdef QUAD_CURSOR_WRAP_EN
        exp_pos = 4;
`else
        exp_pos = 7;
`endif
        check("right_x4", 32'(pos_cursor), 32'(exp_pos));

        // Reach row 2, col 3.
        press(D);
`ifdef QUAD_CURSOR_WRAP_EN
        press(L);
`endif
        wait_frame();
        check("pos_r2c3", 32'(pos_cursor), 32'd11);

        // Request with origin (420, 240), held while not ready; back ignored.
        select_quad();
        check("req_x0", 32'(sel_bus.quad_x0), 32'd420);
        check("req_y0", 32'(sel_bus.quad_y0), 32'd240);
        press(B);
        check("hold_valid", 32'(sel_bus.sel_valid), 32'd1);
        check("hold_x0", 32'(sel_bus.quad_x0), 32'd420);
        check("hold_y0", 32'(sel_bus.quad_y0), 32'd240);
        sel_bus.sel_ready = 1'b1;
        @(negedge clk);
        sel_bus.sel_ready = 1'b0;
        check("valid_fall", 32'(sel_bus.sel_valid), 32'd0);

        // PROCESS ignores buttons; interp_done moves to SHOW.
        press(R);
        press(B);
        sel_bus.interp_done = 1'b1;
        @(negedge clk);
        sel_bus.interp_done = 1'b0;
        check("start_wait_frame", 32'(start), 32'd0);
        wait_frame();
        check("start_rise", 32'(start), 32'd1);
        check("pos_in_show", 32'(pos_cursor), 32'd11);

        // SHOW ignores moves; back returns to BROWSE.
        press(L);
        press(B);
        wait_frame();
        check("start_fall", 32'(start), 32'd0);
        check("pos_after_back", 32'(pos_cursor), 32'd11);

        // Reset in the middle of a request.
        select_quad();
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(sel_bus.sel_valid), 32'd0);
        check("rst_mid_x0", 32'(sel_bus.quad_x0), 32'd120);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_valid_after", 32'(sel_bus.sel_valid), 32'd0);
        wait_frame();
        check("rst_mid_pos", 32'(pos_cursor), 32'd0);
        check("rst_mid_start", 32'(start), 32'd0);
        press(R);
        wait_frame();
        check("browse_after_rst", 32'(pos_cursor), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
